// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: fetch, decode, execute,
// memory, writeback and trap, with bus handshakes and timeout traps.
module multicycle_controller #(
  parameter int TIMEOUT    = 16,
  parameter int WAIT_WIDTH = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [6:0] i_instOP,
  input  logic       i_isIllegal,
  input  logic       i_isLoad,
  input  logic       i_isALU,
  input  logic       i_isECALL,
  input  logic       i_isEBREAK,
  input  logic       i_branchTaken,
  output logic       o_ibusReq,
  input  logic       i_ibusAck,
  output logic       o_dbusReq,
  output logic       o_dbusWe,
  input  logic       i_dbusAck,
  output logic       o_irWrite,
  output logic       o_pcWrite,
  output logic [1:0] o_pcSel,
  output logic       o_regWrite,
  output logic [1:0] o_wbSel,
  output logic       o_trap,
  output logic [3:0] o_trapCause,
  output logic       o_instRetired,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } stateT;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_JAL    = 3'd3,
    CLS_JALR   = 3'd4,
    CLS_BRANCH = 3'd5
  } classT;

  localparam logic [WAIT_WIDTH-1:0] LAST_WAIT = WAIT_WIDTH'(TIMEOUT - 32'sd1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_ONE  = WAIT_WIDTH'(32'sd1);

  stateT                 state;
  classT                 instClass;
  classT                 decodedClass;
  logic [3:0]            cause;
  logic [WAIT_WIDTH-1:0] waitCnt;
  logic                  timeoutHit;

  assign timeoutHit = (TIMEOUT != 32'sd0) && (waitCnt == LAST_WAIT);

  // Instruction class from decoder flags and opcode; LUI/AUIPC behave like ALU ops.
  always_comb begin
    decodedClass = CLS_ALU;
    if (i_isLoad) begin
      decodedClass = CLS_LOAD;
    end else if (i_isALU) begin
      decodedClass = CLS_ALU;
    end else begin
      case (i_instOP)
        7'b0100011: decodedClass = CLS_STORE;
        7'b1101111: decodedClass = CLS_JAL;
        7'b1100111: decodedClass = CLS_JALR;
        7'b1100011: decodedClass = CLS_BRANCH;
        default:    decodedClass = CLS_ALU;
      endcase
    end
  end

  // State register, wait counter and latched class/cause.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state     <= FETCH;
      waitCnt   <= '0;
      instClass <= CLS_ALU;
      cause     <= 4'd0;
    end else begin
      case (state)
        FETCH: begin
          if (i_ibusAck) begin
            state   <= DECODE;
            waitCnt <= '0;
          end else if (timeoutHit) begin
            state   <= TRAP;
            cause   <= 4'd1;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + WAIT_ONE;
          end
        end
        DECODE: begin
          waitCnt <= '0;
          if (i_isIllegal) begin
            state <= TRAP;
            cause <= 4'd2;
          end else if (i_isEBREAK) begin
            state <= TRAP;
            cause <= 4'd3;
          end else if (i_isECALL) begin
            state <= TRAP;
            cause <= 4'd11;
          end else begin
            instClass <= decodedClass;
            state     <= EXECUTE;
          end
        end
        EXECUTE: begin
          waitCnt <= '0;
          if (instClass == CLS_LOAD || instClass == CLS_STORE) begin
            state <= MEMORY;
          end else if (instClass == CLS_BRANCH) begin
            state <= FETCH;
          end else begin
            state <= WRITEBACK;
          end
        end
        MEMORY: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (i_dbusAck) begin
            state   <= (instClass == CLS_LOAD) ? WRITEBACK : FETCH;
            waitCnt <= '0;
          end else if (timeoutHit) begin
            state   <= TRAP;
            cause   <= (instClass == CLS_LOAD) ? 4'd5 : 4'd7;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + WAIT_ONE;
          end
        end
        WRITEBACK: begin
          state   <= FETCH;
          waitCnt <= '0;
        end
        TRAP: begin
          state   <= FETCH;
          waitCnt <= '0;
        end
        default: begin
          state   <= FETCH;
          waitCnt <= '0;
        end
      endcase
    end
  end

  // Moore output decode; everything is forced low while reset is held.
  always_comb begin
    o_ibusReq     = 1'b0;
    o_dbusReq     = 1'b0;
    o_dbusWe      = 1'b0;
    o_irWrite     = 1'b0;
    o_pcWrite     = 1'b0;
    o_pcSel       = 2'd0;
    o_regWrite    = 1'b0;
    o_wbSel       = 2'd0;
    o_trap        = 1'b0;
    o_trapCause   = 4'd0;
    o_instRetired = 1'b0;
    o_state       = 3'd0;
    if (!i_reset) begin
      o_state = 3'd0;
    end else begin
      o_state = state;
      case (state)
        FETCH: begin
          o_ibusReq = 1'b1;
          o_irWrite = i_ibusAck;
        end
        EXECUTE: begin
          if (instClass == CLS_BRANCH) begin
            o_pcWrite     = 1'b1;
            o_pcSel       = i_branchTaken ? 2'd1 : 2'd0;
            o_instRetired = 1'b1;
          end else begin
            o_pcWrite = 1'b0;
          end
        end
        MEMORY: begin
          o_dbusReq = 1'b1;
          o_dbusWe  = (instClass == CLS_STORE);
          if (instClass == CLS_STORE) begin
            o_pcWrite     = i_dbusAck;
            o_instRetired = i_dbusAck;
          end else begin
            o_pcWrite = 1'b0;
          end
        end
        WRITEBACK: begin
          o_regWrite    = 1'b1;
          o_pcWrite     = 1'b1;
          o_instRetired = 1'b1;
          case (instClass)
            CLS_LOAD: o_wbSel = 2'd1;
            CLS_JAL:  begin o_wbSel = 2'd2; o_pcSel = 2'd1; end
            CLS_JALR: begin o_wbSel = 2'd2; o_pcSel = 2'd2; end
            default:  o_wbSel = 2'd0;
          endcase
        end
        TRAP: begin
          o_trap      = 1'b1;
          o_trapCause = cause;
          o_pcWrite   = 1'b1;
          o_pcSel     = 2'd3;
        end
        default: begin
          o_ibusReq = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instruction class per block,
// whole output vector compared against hand-computed values every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       isIllegal, isLoad, isALU, isECALL, isEBREAK, taken;
  logic       ibusAck, dbusAck;
  logic       ibusReq, dbusReq, dbusWe, irWrite, pcWrite, regWrite, trap, instRetired;
  logic [1:0] pcSel, wbSel;
  logic [3:0] trapCause;
  logic [2:0] state;
  logic [18:0] outs;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT(4), .WAIT_WIDTH(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_instOP(op),
    .i_isIllegal(isIllegal), .i_isLoad(isLoad), .i_isALU(isALU),
    .i_isECALL(isECALL), .i_isEBREAK(isEBREAK), .i_branchTaken(taken),
    .o_ibusReq(ibusReq), .i_ibusAck(ibusAck),
    .o_dbusReq(dbusReq), .o_dbusWe(dbusWe), .i_dbusAck(dbusAck),
    .o_irWrite(irWrite), .o_pcWrite(pcWrite), .o_pcSel(pcSel),
    .o_regWrite(regWrite), .o_wbSel(wbSel), .o_trap(trap),
    .o_trapCause(trapCause), .o_instRetired(instRetired), .o_state(state)
  );

  assign outs = {ibusReq, dbusReq, dbusWe, irWrite, pcWrite, pcSel, regWrite,
                 wbSel, trap, trapCause, instRetired, state};

  // Pack expected outputs in the same order as outs.
  function automatic logic [18:0] ev(input int st, input int ibus, input int dbus,
                                     input int we, input int ir, input int pcw,
                                     input int pcs, input int rw, input int wbs,
                                     input int tr, input int cs, input int ret);
    return {1'(ibus), 1'(dbus), 1'(we), 1'(ir), 1'(pcw), 2'(pcs), 1'(rw),
            2'(wbs), 1'(tr), 4'(cs), 1'(ret), 3'(st)};
  endfunction

  // Check one cycle shortly after the falling edge, then move to the next falling edge.
  task automatic cyc(input string tag, input logic [18:0] exp);
    #1;
    nAsserts++;
    assert (outs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, outs, exp);
    end
    @(negedge clk);
  endtask

  task automatic fetchDecode(input string tag, input logic [6:0] o, input logic ld,
                             input logic alu, input logic ec, input logic eb,
                             input logic ill);
    op = o; isLoad = ld; isALU = alu; isECALL = ec; isEBREAK = eb; isIllegal = ill;
    ibusAck = 1'b1;
    cyc({tag, " fetch"}, ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    ibusAck = 1'b0;
    cyc({tag, " decode"}, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b0; op = 7'd0; isIllegal = 1'b0; isLoad = 1'b0; isALU = 1'b0;
    isECALL = 1'b0; isEBREAK = 1'b0; taken = 1'b0; ibusAck = 1'b0; dbusAck = 1'b0;
    @(negedge clk);
    cyc("reset held", 19'd0);
    ibusAck = 1'b1;
    cyc("reset held ack", 19'd0);
    ibusAck = 1'b0;
    rst = 1'b1;

    // ADDI: 0,1,2,4 then back to fetch
    fetchDecode("addi", 7'b0010011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("addi exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("addi wb", ev(4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));

    // LW with three wait cycles; ack in EXECUTE has no request and is ignored
    fetchDecode("lw", 7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    dbusAck = 1'b1;
    cyc("lw exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dbusAck = 1'b0;
    repeat (3) cyc("lw mem wait", ev(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dbusAck = 1'b1;
    cyc("lw mem ack", ev(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dbusAck = 1'b0;
    cyc("lw wb", ev(4, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1));

    // SW with one wait cycle
    fetchDecode("sw", 7'b0100011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("sw exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw mem wait", ev(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    dbusAck = 1'b1;
    cyc("sw mem ack", ev(3, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    dbusAck = 1'b0;

    // Branches: taken then not taken
    taken = 1'b1;
    fetchDecode("beq", 7'b1100011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("beq exec", ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    taken = 1'b0;
    fetchDecode("bne", 7'b1100011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("bne exec", ev(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

    // JAL and JALR
    fetchDecode("jal", 7'b1101111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("jal exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jal wb", ev(4, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 1));
    fetchDecode("jalr", 7'b1100111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("jalr exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jalr wb", ev(4, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 1));

    // Decode traps, with overlapping flags to exercise priority
    fetchDecode("ecall", 7'b1110011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("ecall trap", ev(5, 0, 0, 0, 0, 1, 3, 0, 0, 1, 11, 0));
    fetchDecode("ebreak", 7'b1110011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("ebreak trap", ev(5, 0, 0, 0, 0, 1, 3, 0, 0, 1, 3, 0));
    fetchDecode("illegal", 7'b1111111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("illegal trap", ev(5, 0, 0, 0, 0, 1, 3, 0, 0, 1, 2, 0));

    // Fetch timeout after four unanswered request cycles
    isECALL = 1'b0; isEBREAK = 1'b0; isIllegal = 1'b0;
    repeat (4) cyc("fetch wait", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("fetch timeout trap", ev(5, 0, 0, 0, 0, 1, 3, 0, 0, 1, 1, 0));

    // Ack on the last allowed cycle wins over the timeout
    op = 7'b0010011; isALU = 1'b1;
    repeat (3) cyc("fetch late wait", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    ibusAck = 1'b1;
    cyc("fetch late ack", ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    ibusAck = 1'b0;
    cyc("late decode", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("late exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("late wb", ev(4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));

    // Store timeout
    fetchDecode("sw to", 7'b0100011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("sw to exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (4) cyc("sw to mem", ev(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw timeout trap", ev(5, 0, 0, 0, 0, 1, 3, 0, 0, 1, 7, 0));

    // Reset during MEMORY aborts the load
    fetchDecode("lw rst", 7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lw rst exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw rst mem", ev(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0; dbusAck = 1'b1;
    cyc("reset in memory", 19'd0);
    rst = 1'b1; dbusAck = 1'b0;
    fetchDecode("post reset", 7'b0010011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("post reset exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("post reset wb", ev(4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
